vram_row_fetch: RTL and testbench

- Memory-side responder to the display row-buffer request interface.
- On a row request (vram_re plus vram_y), reads one display row of 16-bit BGR555 pixels from VRAM through a pipelined read port.
- Expands each pixel to 24-bit colour and writes it into the display row buffer via vram_we / vram_x / vram_out.
- Sits in the clk_33MHz GPU domain between the VRAM arbiter and the display output block.

---
 rtl/vram_row_fetch_if.sv | 27 ++
 rtl/vram_row_fetch.sv | 127 ++++++++++++
 tb/tb_vram_row_fetch.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_row_fetch_if.sv
// Bundles the row-request, VRAM read-port and row-buffer write signals of vram_row_fetch.
// The fetcher owns the master modport; the request source, VRAM port and row buffer share the slave modport.
`timescale 1ns/1ps
interface vram_row_fetch_if;
  logic        vram_re;
  logic [8:0]  vram_y;
  logic [9:0]  x_tl;
  logic        mem_rd;
  logic [18:0] mem_addr;
  logic        mem_rdy;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        vram_we;
  logic [9:0]  vram_x;
  logic [23:0] vram_out;
  logic        busy;

  modport master (
    input  vram_re, vram_y, x_tl, mem_rdy, mem_rvalid, mem_rdata,
    output mem_rd, mem_addr, vram_we, vram_x, vram_out, busy
  );

  modport slave (
    output vram_re, vram_y, x_tl, mem_rdy, mem_rvalid, mem_rdata,
    input  mem_rd, mem_addr, vram_we, vram_x, vram_out, busy
  );
endinterface

// File: rtl/vram_row_fetch.sv
// Fetches one display row of BGR555 pixels from VRAM through a pipelined read port.
// Each pixel is expanded to 24-bit colour and written into the display row buffer.
`timescale 1ns/1ps
module vram_row_fetch #(
  parameter int ROW_W   = 640,
  parameter int MAX_OUT = 4
) (
  input  logic              clk_33MHz,
  input  logic              rst,
  vram_row_fetch_if.master  bus
);

  localparam logic [10:0] ROW_LAST = 11'(ROW_W);
  localparam logic [3:0]  OUT_LIM  = 4'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state;
  logic [8:0]  row;
  logic [9:0]  col0;
  logic [9:0]  req_cnt;
  logic [9:0]  ret_cnt;
  logic [3:0]  outstanding;
  logic        pend;
  logic [8:0]  pend_row;
  logic [9:0]  pend_col;

  logic        accept;
  logic        ret;
  logic [10:0] req_next;
  logic [3:0]  out_next;
  logic [9:0]  col_next;

  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Returns are ignored in IDLE so stale data after a reset never reaches the row buffer.
  always_comb begin
    accept   = bus.mem_rd & bus.mem_rdy;
    ret      = bus.mem_rvalid & (state != IDLE);
    req_next = {1'b0, req_cnt} + {10'd0, accept};
    out_next = outstanding + {3'd0, accept} - {3'd0, ret};
    col_next = col0 + req_next[9:0];
  end

  always_ff @(posedge clk_33MHz) begin
    if (rst) begin
      state        <= IDLE;
      row          <= '0;
      col0         <= '0;
      req_cnt      <= '0;
      ret_cnt      <= '0;
      outstanding  <= '0;
      pend         <= 1'b0;
      pend_row     <= '0;
      pend_col     <= '0;
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
      bus.vram_we  <= 1'b0;
      bus.vram_x   <= '0;
      bus.vram_out <= '0;
      bus.busy     <= 1'b0;
    end else begin
      bus.vram_we <= 1'b0;
      outstanding <= out_next;

      if (ret) begin
        bus.vram_we  <= 1'b1;
        bus.vram_x   <= ret_cnt;
        bus.vram_out <= {expand5(bus.mem_rdata[14:10]),
                         expand5(bus.mem_rdata[9:5]),
                         expand5(bus.mem_rdata[4:0])};
        ret_cnt      <= ret_cnt + 10'd1;
      end

      // A request seen while busy is parked; the newest one wins.
      if (bus.vram_re && state != IDLE) begin
        pend     <= 1'b1;
        pend_row <= bus.vram_y;
        pend_col <= bus.x_tl;
      end

      case (state)
        IDLE: begin
          if (pend || bus.vram_re) begin
            state        <= REQ;
            bus.busy     <= 1'b1;
            bus.mem_rd   <= 1'b1;
            req_cnt      <= '0;
            ret_cnt      <= '0;
            row          <= pend ? pend_row : bus.vram_y;
            col0         <= pend ? pend_col : bus.x_tl;
            bus.mem_addr <= pend ? {pend_row, pend_col} : {bus.vram_y, bus.x_tl};
          end
          pend <= pend & bus.vram_re;
          if (pend && bus.vram_re) begin
            pend_row <= bus.vram_y;
            pend_col <= bus.x_tl;
          end
        end

        REQ: begin
          req_cnt <= req_next[9:0];
          if (req_next == ROW_LAST) begin
            bus.mem_rd <= 1'b0;
            state      <= DRAIN;
          end else begin
            // The address only moves after an accept, so it holds steady through a stall.
            bus.mem_rd   <= (out_next < OUT_LIM);
            bus.mem_addr <= {row, col_next};
          end
        end

        DRAIN: begin
          if ({1'b0, ret_cnt} == ROW_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_row_fetch.sv
// Scoreboard bench for vram_row_fetch: stimulus queues expected reads and writes,
// a VRAM model and a row-buffer monitor pop and compare independently.
`timescale 1ns/1ps
module tb_vram_row_fetch;
  localparam int ROW_W   = 640;
  localparam int MAX_OUT = 4;

  logic clk_33MHz = 1'b0;
  logic rst       = 1'b1;
  always #15 clk_33MHz = ~clk_33MHz;

  vram_row_fetch_if bus();

  vram_row_fetch #(.ROW_W(ROW_W), .MAX_OUT(MAX_OUT)) dut (
    .clk_33MHz (clk_33MHz),
    .rst       (rst),
    .bus       (bus)
  );

  typedef struct packed {
    logic [9:0]  x;
    logic [23:0] out;
  } wr_t;

  wr_t         exp_wr[$];
  logic [18:0] exp_addr[$];
  int          ret_due[$];
  logic [15:0] ret_dat[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_total = 0;
  int last_we_cyc = -1;
  int data_mode = 0;
  int lat = 3;
  int rdy_mode = 0;
  int stale_req = 0;
  int stale_done = 0;
  int mem_out = 0;
  bit rdy_phase = 1'b0;
  bit stall_prev = 1'b0;
  bit rst_prev = 1'b1;
  logic [18:0] stall_addr = '0;
  logic [23:0] hand [3] = '{24'hFFFFFF, 24'h000000, 24'h848484};

  always @(posedge clk_33MHz) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] up5(input logic [4:0] c);
    logic [7:0] w;
    w = 8'(c) << 3;
    w = w | 8'(c >> 2);
    return w;
  endfunction

  function automatic logic [23:0] expect_pix(input logic [15:0] p);
    return {up5(p[14:10]), up5(p[9:5]), up5(p[4:0])};
  endfunction

  function automatic logic [15:0] pixel_for(input logic [9:0] col);
    if (data_mode == 1 && col == 10'd0) return 16'h7FFF;
    if (data_mode == 1 && col == 10'd1) return 16'h0000;
    if (data_mode == 1 && col == 10'd2) return 16'h4210;
    return {6'd0, col};
  endfunction

  // Row-buffer monitor: every write must match the head of the expected queue.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk_33MHz);
      if (rst_prev) begin
        exp_wr.delete();
        checkOutput("we_in_reset", 32'(bus.vram_we), 32'd0);
      end else if (bus.vram_we === 1'b1) begin
        last_we_cyc = cyc;
        wr_total++;
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got x=%0d out=0x%0h, want no write (cycle %0d)",
                   bus.vram_x, bus.vram_out, cyc);
        end else begin
          e = exp_wr.pop_front();
          checkOutput("vram_x", 32'(bus.vram_x), 32'(e.x));
          checkOutput("vram_out", 32'(bus.vram_out), 32'(e.out));
        end
      end
      rst_prev = rst;
    end
  end

  // VRAM model: checks each accepted address, returns data after a fixed latency.
  initial begin : mem_model
    bus.mem_rdy    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(negedge clk_33MHz);
      if (rst) begin
        ret_due.delete();
        ret_dat.delete();
        exp_addr.delete();
        mem_out        = 0;
        stall_prev     = 1'b0;
        bus.mem_rdy    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end else begin
        if (stall_prev)
          checkOutput("addr_hold", {12'd0, bus.mem_rd, bus.mem_addr}, {12'd0, 1'b1, stall_addr});
        rdy_phase   = ~rdy_phase;
        bus.mem_rdy = (rdy_mode == 0) ? 1'b1 : rdy_phase;
        if (bus.mem_rd === 1'b1) begin
          checkOutput("outstanding_lt_max", 32'(mem_out < MAX_OUT), 32'd1);
          if (bus.mem_rdy) begin
            if (exp_addr.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_read: got addr=0x%0h, want no read (cycle %0d)",
                       bus.mem_addr, cyc);
            end else begin
              checkOutput("mem_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            ret_due.push_back(cyc + 1 + lat);
            ret_dat.push_back(pixel_for(bus.mem_addr[9:0]));
            mem_out++;
          end
        end
        stall_prev = (bus.mem_rd === 1'b1) && !bus.mem_rdy;
        stall_addr = bus.mem_addr;
        if (ret_due.size() > 0 && ret_due[0] <= cyc + 1) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = ret_dat.pop_front();
          void'(ret_due.pop_front());
          mem_out--;
        end else if (stale_done < stale_req) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 16'h7FFF;
          stale_done++;
        end else begin
          bus.mem_rvalid = 1'b0;
          bus.mem_rdata  = '0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [8:0] y, input logic [9:0] x, input bit track);
    logic [9:0]  col;
    logic [23:0] exp_out;
    if (track) begin
      for (int i = 0; i < ROW_W; i++) begin
        col = x + 10'(i);
        exp_addr.push_back({y, col});
        exp_out = (data_mode == 1 && i < 3) ? hand[i] : expect_pix(pixel_for(col));
        exp_wr.push_back('{x: 10'(i), out: exp_out});
      end
    end
    bus.vram_y  = y;
    bus.x_tl    = x;
    bus.vram_re = 1'b1;
    @(negedge clk_33MHz);
    bus.vram_re = 1'b0;
    bus.vram_y  = 9'h1AA;
    bus.x_tl    = 10'h2B3;
  endtask

  task automatic waitIdle(input string name, input int budget, input int start_wr);
    int n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clk_33MHz);
      n++;
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got busy=%b after %0d cycles, want 0", name, bus.busy, n);
    end else begin
      checkOutput({name, "_writes"}, 32'(wr_total - start_wr), 32'(ROW_W));
      checkOutput({name, "_busy_fall"}, 32'(cyc), 32'(last_we_cyc + 1));
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_mem_rd"},   32'(bus.mem_rd),   32'd0);
    checkOutput({name, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    checkOutput({name, "_vram_we"},  32'(bus.vram_we),  32'd0);
    checkOutput({name, "_vram_x"},   32'(bus.vram_x),   32'd0);
    checkOutput({name, "_vram_out"}, 32'(bus.vram_out), 32'd0);
    checkOutput({name, "_busy"},     32'(bus.busy),     32'd0);
  endtask

  initial begin : stimulus
    int start;
    int n;
    bus.vram_re = 1'b0;
    bus.vram_y  = '0;
    bus.x_tl    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk_33MHz);
    checkReset("init");
    rst = 1'b0;
    repeat (2) @(negedge clk_33MHz);

    // Row 5 from column 0: addresses 0x01400..0x0167F, pixel = column.
    $display("[TB] basic fetch");
    start = wr_total;
    applyStimulus(9'd5, 10'd0, 1'b1);
    waitIdle("basic", 4000, start);
    checkOutput("basic_queue", 32'(exp_wr.size()), 32'd0);

    $display("[TB] colour expansion");
    data_mode = 1;
    start = wr_total;
    applyStimulus(9'd2, 10'd0, 1'b1);
    waitIdle("colour", 4000, start);
    data_mode = 0;

    $display("[TB] throttle and backpressure");
    lat = 10;
    rdy_mode = 1;
    start = wr_total;
    applyStimulus(9'd6, 10'd100, 1'b1);
    waitIdle("throttle", 8000, start);
    lat = 3;
    rdy_mode = 0;
    repeat (2) @(negedge clk_33MHz);

    $display("[TB] column wrap");
    start = wr_total;
    applyStimulus(9'd0, 10'd1000, 1'b1);
    waitIdle("wrap", 4000, start);

    // y=8 is overwritten by y=9 before row 7 finishes.
    $display("[TB] request during busy");
    start = wr_total;
    applyStimulus(9'd7, 10'd0, 1'b1);
    repeat (5) @(negedge clk_33MHz);
    applyStimulus(9'd8, 10'd50, 1'b0);
    repeat (5) @(negedge clk_33MHz);
    applyStimulus(9'd9, 10'd300, 1'b1);
    waitIdle("pend_y7", 4000, start);
    @(negedge clk_33MHz);
    checkOutput("pend_start_rd", 32'(bus.mem_rd), 32'd1);
    checkOutput("pend_start_addr", 32'(bus.mem_addr), 32'h0000252C);
    checkOutput("pend_start_busy", 32'(bus.busy), 32'd1);
    start = wr_total;
    waitIdle("pend_y9", 4000, start);
    repeat (20) @(negedge clk_33MHz);
    checkOutput("no_third_row_busy", 32'(bus.busy), 32'd0);
    checkOutput("no_third_row_addrs", 32'(exp_addr.size()), 32'd0);

    $display("[TB] reset mid-row");
    start = wr_total;
    applyStimulus(9'd3, 10'd0, 1'b1);
    n = 0;
    while (wr_total - start < 100 && n < 2000) begin
      @(negedge clk_33MHz);
      n++;
    end
    checkOutput("writes_at_reset", 32'(wr_total - start), 32'd100);
    rst = 1'b1;
    repeat (2) @(negedge clk_33MHz);
    checkReset("mid_reset");
    rst = 1'b0;
    stale_req = stale_req + 3;
    repeat (10) @(negedge clk_33MHz);
    checkReset("after_stale");
    checkOutput("no_write_after_reset", 32'(wr_total - start), 32'd100);
    start = wr_total;
    applyStimulus(9'd4, 10'd20, 1'b1);
    waitIdle("after_reset", 4000, start);
    checkOutput("final_queue", 32'(exp_wr.size()), 32'd0);

    repeat (3) @(negedge clk_33MHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: got no finish after 100000 cycles, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
